// File: rtl/regfile_wb.sv
// Write-back register file: 2**AW x N, r0 hardwired to zero.
// Two combinational read ports with write bypass, plus a zero flag.
module regfile_wb #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  a,
  output logic [N-1:0]  b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          flag_we,
  input  logic          zf_in,
  output logic          zf
);

  localparam int D = 1 << AW;

  logic [D-1:0][N-1:0] mem;
  logic                wr_ok;

  assign wr_ok = we && (waddr != '0);

  // register storage: reset clears all, writes to r0 are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // zero flag: registered only, no path from zf_in to zf
  always_ff @(posedge clk) begin
    if (reset) begin
      zf <= 1'b0;
    end else if (flag_we) begin
      zf <= zf_in;
    end
  end

  // port A: r0 is zero, bypass beats storage, storage masked in reset
  always_comb begin
    a = '0;
    if (raddr_a != '0) begin
      if (wr_ok && (waddr == raddr_a)) begin
        a = wdata;
      end else if (!reset) begin
        a = mem[raddr_a];
      end
    end
  end

  // port B: same selection as port A
  always_comb begin
    b = '0;
    if (raddr_b != '0) begin
      if (wr_ok && (waddr == raddr_b)) begin
        b = wdata;
      end else if (!reset) begin
        b = mem[raddr_b];
      end
    end
  end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
- REQ-001 SHALL have parameter N, default 8: data width of every register, read port and write port.
- REQ-002 SHALL have parameter AW, default 3: address width; register count is 2**AW (8 at defaults).
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
- REQ-005 SHALL have port raddr_a  input  AW  read address for operand port A.
- REQ-006 SHALL have port raddr_b  input  AW  read address for operand port B.
- REQ-007 SHALL have port a  output  N  operand A, drives ALU input a.
- REQ-008 SHALL have port b  output  N  operand B, drives ALU input b.
- REQ-009 SHALL have port we  input  1  register write enable (write-back of ALU result).
- REQ-010 SHALL have port waddr  input  AW  write-back destination address.
- REQ-011 SHALL have port wdata  input  N  write-back data, driven by ALU result.
- REQ-012 SHALL have port flag_we  input  1  zero-flag update enable.
- REQ-013 SHALL have port zf_in  input  1  ALU ZF output.
- REQ-014 SHALL have port zf  output  1  registered zero flag, consumed by branch logic.

Function
- REQ-015 SHALL hold 2**AW registers of N bits; register 0 reads as 0 at all times.
- REQ-016 SHALL write wdata into register waddr on rising clk when we=1, reset=0, waddr!=0.
- REQ-017 SHALL ignore any write to address 0; register 0 contents remain 0.
- REQ-018 SHALL drive a and b combinationally from stored contents of raddr_a and raddr_b (zero-latency read).
- REQ-019 SHALL bypass: when we=1, waddr!=0, and waddr==raddr_a, a SHALL equal wdata in the same cycle; likewise b for raddr_b.
- REQ-020 SHALL apply bypass to both ports simultaneously when raddr_a==raddr_b==waddr.
- REQ-021 SHALL NOT bypass when waddr=0; a/b read 0 for address 0 regardless of we/wdata.
- REQ-022 SHALL load zf from zf_in on rising clk when flag_we=1 and reset=0; otherwise zf holds.
- REQ-023 SHALL update zf and register write independently in the same cycle when both enables are set.
- REQ-024 SHALL have one-cycle write-to-stored latency: data written at edge k is read from storage from cycle k onward without bypass.
- REQ-025 SHALL make consecutive writes to the same address last-writer-wins; no write SHALL be lost or reordered.
- REQ-026 SHALL contain no combinational path from zf_in to zf.

Reset
- REQ-027 SHALL clear every register and zf to 0 on a rising clk with reset=1.
- REQ-028 SHALL give reset priority over we and flag_we in the same cycle; the write and flag update are discarded.
- REQ-029 SHALL, while reset is held, drive a=0 and b=0 for any addresses, except bypass values while we=1 (bypass stays combinational; storage is cleared at the edge).
- REQ-030 SHALL resume normal writes on the first rising edge after reset deasserts.

Verification
- REQ-031 SHALL cover: reset, then raddr_a=3, raddr_b=5 -> a=0, b=0, zf=0.
- REQ-032 SHALL cover: we=1, waddr=3, wdata=8'h16, clock, we=0, raddr_a=3 -> a=8'h16; raddr_b=3 -> b=8'h16.
- REQ-033 SHALL cover: we=1, waddr=4, wdata=8'hA5, raddr_a=raddr_b=4 before edge -> a=b=8'hA5 same cycle (bypass).
- REQ-034 SHALL cover: we=1, waddr=0, wdata=8'hFF, clock; raddr_a=0 -> a=0 before and after edge.
- REQ-035 SHALL cover: flag_we=1, zf_in=1, clock -> zf=1; flag_we=0, zf_in=0, clock -> zf stays 1; flag_we=1, zf_in=0, clock -> zf=0.
- REQ-036 SHALL cover: reg2=8'h11 stored, then reset=1 with we=1, waddr=2, wdata=8'h22, flag_we=1, zf_in=1, clock; reset=0 -> reg2 reads 0, zf=0.
